// File: rtl/data_memory_ctrl_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_memory_ctrl_if : request/response and clear-control bundle for data_memory_ctrl
// Rev 1.0
// -----------------------------------------------------------------------------
interface data_memory_ctrl_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  rsp_valid;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  clear_start;
   logic                  busy;
   logic                  clear_done;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, clear_start,
      input  req_ready, rsp_valid, rsp_rdata, busy, clear_done
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, clear_start,
      output req_ready, rsp_valid, rsp_rdata, busy, clear_done
   );
endinterface
`default_nettype wire

// File: rtl/data_memory_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// data_memory_ctrl : single-port data RAM, valid/ready access, hardware clear sweep
// Rev 1.0
// -----------------------------------------------------------------------------
module data_memory_ctrl #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    ADDR_WIDTH     = 8,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  wire logic         clk,
   input  wire logic         rst_n,
   data_memory_ctrl_if.slave bus
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam state_t c_RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;

   state_t                r_state;
   state_t                w_state_next;
   logic [ADDR_WIDTH-1:0] r_cnt;
   logic [ADDR_WIDTH-1:0] w_cnt_next;
   logic                  r_clear_done;
   logic                  w_done_next;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_busy;
   logic                  w_accept;
   logic                  w_rd_accept;
   logic                  w_mem_we;
   logic [ADDR_WIDTH-1:0] w_mem_addr;
   logic [DATA_WIDTH-1:0] w_mem_wdata;

   assign w_busy      = (r_state == ST_CLEAR);
   assign w_accept    = bus.req_valid && !w_busy;
   assign w_rd_accept = w_accept && !bus.req_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= c_RESET_STATE;
         r_cnt        <= '0;
         r_clear_done <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_cnt        <= w_cnt_next;
         r_clear_done <= w_done_next;
      end
   end

   // The single RAM write port is owned by the sweep while clearing, by the requester otherwise.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_done_next  = 1'b0;
      w_mem_we     = 1'b0;
      w_mem_addr   = bus.req_addr;
      w_mem_wdata  = bus.req_wdata;
      case (r_state)
         ST_IDLE: begin
            w_mem_we = w_accept && bus.req_write;
            if (bus.clear_start) begin
               w_state_next = ST_CLEAR;
               w_cnt_next   = '0;
            end
         end
         ST_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_cnt;
            w_mem_wdata = CLEAR_VALUE;
            w_cnt_next  = r_cnt + 1'b1;
            if (r_cnt == c_LAST_ADDR) begin
               w_state_next = ST_IDLE;
               w_done_next  = 1'b1;
            end
         end
      endcase
   end

   // Array contents deliberately survive rst_n.
   always_ff @(posedge clk) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         r_rsp_valid <= w_rd_accept;
         if (w_rd_accept) begin
            r_rsp_rdata <= r_mem[bus.req_addr];
         end
      end
   end

   assign bus.req_ready  = !w_busy;
   assign bus.busy       = w_busy;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_rdata  = r_rsp_rdata;
   assign bus.clear_done = r_clear_done;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl : self-checking bench, two 8-bit instances plus one 16-bit instance
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;
   localparam logic [7:0]  c_CV_A = 8'h00;
   localparam logic [7:0]  c_CV_B = 8'hEE;
   localparam logic [15:0] c_CV_C = 16'h1234;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   logic [7:0]  ref_a [256];
   logic [7:0]  ref_b [256];
   logic [15:0] ref_c [16];

   data_memory_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) if_a ();
   data_memory_ctrl_if #(.DATA_WIDTH(8),  .ADDR_WIDTH(8)) if_b ();
   data_memory_ctrl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) if_c ();

   // Instance B mirrors A's stimulus and differs only in its clear value.
   assign if_b.req_valid   = if_a.req_valid;
   assign if_b.req_write   = if_a.req_write;
   assign if_b.req_addr    = if_a.req_addr;
   assign if_b.req_wdata   = if_a.req_wdata;
   assign if_b.clear_start = if_a.clear_start;

   data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CLEAR_ON_RESET(1), .CLEAR_VALUE(c_CV_A))
      u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
   data_memory_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .CLEAR_ON_RESET(1), .CLEAR_VALUE(c_CV_B))
      u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
   data_memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(0), .CLEAR_VALUE(c_CV_C))
      u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic wr, input logic [7:0] addr, input logic [7:0] data);
      if_a.req_valid = 1'b1;
      if_a.req_write = wr;
      if_a.req_addr  = addr;
      if_a.req_wdata = data;
      tick();
      if_a.req_valid = 1'b0;
      if (wr) begin
         ref_a[addr] = data;
         ref_b[addr] = data;
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) begin
         ref_a[i] = c_CV_A;
         ref_b[i] = c_CV_B;
      end
   endtask

   // Observes 300 cycles from the current sample point: busy cycles, done pulses, ready/busy disagreements.
   task automatic measure_sweep(output int nb_a, output int nd_a, output int nb_b,
                                output int nd_b, output int nr);
      nb_a = 0; nd_a = 0; nb_b = 0; nd_b = 0; nr = 0;
      for (int i = 0; i < 300; i++) begin
         if (if_a.busy === 1'b1) nb_a++;
         if (if_b.busy === 1'b1) nb_b++;
         if (if_a.clear_done === 1'b1) nd_a++;
         if (if_b.clear_done === 1'b1) nd_b++;
         if (if_a.req_ready !== !if_a.busy || if_b.req_ready !== !if_b.busy) nr++;
         tick();
      end
   endtask

   task automatic test_reset();
      int nb_a, nd_a, nb_b, nd_b, nr;
      logic [7:0] addrs [3];
      addrs = '{8'h00, 8'h7F, 8'hFF};
      rst_n = 1'b0;
      tick();
      tick();
      n_checks++; if (if_a.busy !== 1'b1) begin n_errors++; $display("FAIL reset_busy_a: got %b expected 1", if_a.busy); end
      n_checks++; if (if_a.req_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready_a: got %b expected 0", if_a.req_ready); end
      n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid_a: got %b expected 0", if_a.rsp_valid); end
      n_checks++; if (if_a.rsp_rdata !== 8'h00) begin n_errors++; $display("FAIL reset_rdata_a: got %h expected 00", if_a.rsp_rdata); end
      n_checks++; if (if_a.clear_done !== 1'b0) begin n_errors++; $display("FAIL reset_done_a: got %b expected 0", if_a.clear_done); end
      n_checks++; if (if_c.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy_c: got %b expected 0", if_c.busy); end
      n_checks++; if (if_c.req_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready_c: got %b expected 1", if_c.req_ready); end
      rst_n = 1'b1;
      measure_sweep(nb_a, nd_a, nb_b, nd_b, nr);
      n_checks++; if (nb_a != 256) begin n_errors++; $display("FAIL reset_sweep_len_a: got %0d expected 256", nb_a); end
      n_checks++; if (nd_a != 1) begin n_errors++; $display("FAIL reset_done_count_a: got %0d expected 1", nd_a); end
      n_checks++; if (nb_b != 256) begin n_errors++; $display("FAIL reset_sweep_len_b: got %0d expected 256", nb_b); end
      n_checks++; if (nd_b != 1) begin n_errors++; $display("FAIL reset_done_count_b: got %0d expected 1", nd_b); end
      n_checks++; if (nr != 0) begin n_errors++; $display("FAIL reset_ready_vs_busy: got %0d bad cycles expected 0", nr); end
      model_clear();
      for (int k = 0; k < 3; k++) begin
         issue(1'b0, addrs[k], 8'h00);
         n_checks++; if (if_a.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL cleared_rsp_valid @%h: got %b expected 1", addrs[k], if_a.rsp_valid); end
         n_checks++; if (if_a.rsp_rdata !== ref_a[addrs[k]]) begin n_errors++; $display("FAIL cleared_rdata_a @%h: got %h expected %h", addrs[k], if_a.rsp_rdata, ref_a[addrs[k]]); end
         n_checks++; if (if_b.rsp_rdata !== ref_b[addrs[k]]) begin n_errors++; $display("FAIL cleared_rdata_b @%h: got %h expected %h", addrs[k], if_b.rsp_rdata, ref_b[addrs[k]]); end
      end
   endtask

   task automatic test_write_read();
      issue(1'b1, 8'h10, 8'hA5);
      n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL write_no_rsp: got %b expected 0", if_a.rsp_valid); end
      issue(1'b0, 8'h10, 8'h00);
      n_checks++; if (if_a.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL wr_rd_valid: got %b expected 1", if_a.rsp_valid); end
      n_checks++; if (if_a.rsp_rdata !== 8'hA5) begin n_errors++; $display("FAIL wr_rd_data: got %h expected a5", if_a.rsp_rdata); end
      tick();
      n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL wr_rd_valid_drop: got %b expected 0", if_a.rsp_valid); end
      n_checks++; if (if_a.rsp_rdata !== 8'hA5) begin n_errors++; $display("FAIL wr_rd_data_hold: got %h expected a5", if_a.rsp_rdata); end
   endtask

   task automatic test_clear_with_read();
      int nb_a, nd_a, nb_b, nd_b, nr;
      issue(1'b1, 8'h20, 8'h3C);
      if_a.req_valid   = 1'b1;
      if_a.req_write   = 1'b0;
      if_a.req_addr    = 8'h20;
      if_a.clear_start = 1'b1;
      tick();
      if_a.req_valid   = 1'b0;
      if_a.clear_start = 1'b0;
      n_checks++; if (if_a.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL clr_rd_valid: got %b expected 1", if_a.rsp_valid); end
      n_checks++; if (if_a.rsp_rdata !== 8'h3C) begin n_errors++; $display("FAIL clr_rd_predata_a: got %h expected 3c", if_a.rsp_rdata); end
      n_checks++; if (if_b.rsp_rdata !== 8'h3C) begin n_errors++; $display("FAIL clr_rd_predata_b: got %h expected 3c", if_b.rsp_rdata); end
      n_checks++; if (if_a.busy !== 1'b1) begin n_errors++; $display("FAIL clr_busy_rise: got %b expected 1", if_a.busy); end
      measure_sweep(nb_a, nd_a, nb_b, nd_b, nr);
      n_checks++; if (nb_a != 256 || nb_b != 256) begin n_errors++; $display("FAIL clr_sweep_len: got %0d/%0d expected 256", nb_a, nb_b); end
      n_checks++; if (nd_a != 1 || nd_b != 1) begin n_errors++; $display("FAIL clr_done_count: got %0d/%0d expected 1", nd_a, nd_b); end
      model_clear();
      issue(1'b0, 8'h20, 8'h00);
      n_checks++; if (if_a.rsp_rdata !== ref_a[8'h20]) begin n_errors++; $display("FAIL clr_after_a: got %h expected %h", if_a.rsp_rdata, ref_a[8'h20]); end
      n_checks++; if (if_b.rsp_rdata !== ref_b[8'h20]) begin n_errors++; $display("FAIL clr_after_b: got %h expected %h", if_b.rsp_rdata, ref_b[8'h20]); end
   endtask

   task automatic test_hold_during_sweep();
      int n     = 0;
      int n_bad = 0;
      if_a.clear_start = 1'b1;
      tick();
      if_a.clear_start = 1'b0;
      if_a.req_valid   = 1'b1;
      if_a.req_write   = 1'b0;
      if_a.req_addr    = 8'h05;
      while (if_a.busy === 1'b1 && n < 300) begin
         if (if_a.req_ready !== 1'b0 || if_a.rsp_valid !== 1'b0 || if_b.rsp_valid !== 1'b0) n_bad++;
         tick();
         n++;
      end
      model_clear();
      n_checks++; if (n != 256) begin n_errors++; $display("FAIL hold_busy_len: got %0d expected 256", n); end
      n_checks++; if (n_bad != 0) begin n_errors++; $display("FAIL hold_accepted_in_sweep: got %0d bad cycles expected 0", n_bad); end
      n_checks++; if (if_a.clear_done !== 1'b1) begin n_errors++; $display("FAIL hold_done_first_idle: got %b expected 1", if_a.clear_done); end
      n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL hold_early_rsp: got %b expected 0", if_a.rsp_valid); end
      tick();
      if_a.req_valid = 1'b0;
      n_checks++; if (if_a.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL hold_rsp_valid: got %b expected 1", if_a.rsp_valid); end
      n_checks++; if (if_b.rsp_rdata !== ref_b[8'h05]) begin n_errors++; $display("FAIL hold_rdata_b: got %h expected %h", if_b.rsp_rdata, ref_b[8'h05]); end
   endtask

   task automatic test_reset_mid_op();
      int nb_a, nd_a, nb_b, nd_b, nr;
      issue(1'b0, 8'h33, 8'h00);
      rst_n = 1'b0;
      #1;
      n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midread_rsp_clear: got %b expected 0", if_a.rsp_valid); end
      n_checks++; if (if_a.busy !== 1'b1) begin n_errors++; $display("FAIL midread_busy: got %b expected 1", if_a.busy); end
      tick();
      tick();
      rst_n = 1'b1;
      measure_sweep(nb_a, nd_a, nb_b, nd_b, nr);
      n_checks++; if (nb_a != 256 || nd_a != 1) begin n_errors++; $display("FAIL midread_sweep: got %0d cycles %0d dones expected 256 1", nb_a, nd_a); end
      issue(1'b1, 8'h00, 8'h5A);
      if_a.clear_start = 1'b1;
      tick();
      if_a.clear_start = 1'b0;
      repeat (100) tick();
      rst_n = 1'b0;
      #1;
      n_checks++; if (if_a.busy !== 1'b1) begin n_errors++; $display("FAIL midsweep_busy: got %b expected 1", if_a.busy); end
      tick();
      tick();
      rst_n = 1'b1;
      measure_sweep(nb_a, nd_a, nb_b, nd_b, nr);
      model_clear();
      n_checks++; if (nb_a != 256 || nb_b != 256) begin n_errors++; $display("FAIL midsweep_len: got %0d/%0d expected 256", nb_a, nb_b); end
      n_checks++; if (nd_a != 1 || nd_b != 1) begin n_errors++; $display("FAIL midsweep_done: got %0d/%0d expected 1", nd_a, nd_b); end
      issue(1'b0, 8'h00, 8'h00);
      n_checks++; if (if_b.rsp_rdata !== ref_b[8'h00]) begin n_errors++; $display("FAIL midsweep_rdata_b: got %h expected %h", if_b.rsp_rdata, ref_b[8'h00]); end
   endtask

   task automatic test_random();
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      for (int i = 0; i < 300; i++) begin
         wr   = 1'($urandom_range(0, 1));
         addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         data = 8'($urandom);
         issue(wr, addr, data);
         if (!wr) begin
            n_checks++; if (if_a.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL rand_valid @%h: got %b expected 1", addr, if_a.rsp_valid); end
            n_checks++; if (if_a.rsp_rdata !== ref_a[addr]) begin n_errors++; $display("FAIL rand_rdata_a @%h: got %h expected %h", addr, if_a.rsp_rdata, ref_a[addr]); end
            n_checks++; if (if_b.rsp_rdata !== ref_b[addr]) begin n_errors++; $display("FAIL rand_rdata_b @%h: got %h expected %h", addr, if_b.rsp_rdata, ref_b[addr]); end
         end
         if ($urandom_range(0, 3) == 0) tick();
      end
   endtask

   task automatic test_small_config();
      int n = 0;
      n_checks++; if (if_c.busy !== 1'b0) begin n_errors++; $display("FAIL small_idle_busy: got %b expected 0", if_c.busy); end
      if_c.req_valid = 1'b1;
      if_c.req_write = 1'b1;
      if_c.req_addr  = 4'hF;
      if_c.req_wdata = 16'hBEEF;
      ref_c[15]      = 16'hBEEF;
      tick();
      if_c.req_write = 1'b0;
      tick();
      if_c.req_valid = 1'b0;
      n_checks++; if (if_c.rsp_valid !== 1'b1) begin n_errors++; $display("FAIL small_rsp_valid: got %b expected 1", if_c.rsp_valid); end
      n_checks++; if (if_c.rsp_rdata !== ref_c[15]) begin n_errors++; $display("FAIL small_rdata: got %h expected %h", if_c.rsp_rdata, ref_c[15]); end
      if_c.clear_start = 1'b1;
      tick();
      if_c.clear_start = 1'b0;
      while (if_c.busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      for (int i = 0; i < 16; i++) ref_c[i] = c_CV_C;
      n_checks++; if (n != 16) begin n_errors++; $display("FAIL small_sweep_len: got %0d expected 16", n); end
      n_checks++; if (if_c.clear_done !== 1'b1) begin n_errors++; $display("FAIL small_done: got %b expected 1", if_c.clear_done); end
      if_c.req_valid = 1'b1;
      tick();
      if_c.req_valid = 1'b0;
      n_checks++; if (if_c.rsp_rdata !== ref_c[15]) begin n_errors++; $display("FAIL small_cleared: got %h expected %h", if_c.rsp_rdata, ref_c[15]); end
   endtask

   initial begin
      if_a.req_valid   = 1'b0;
      if_a.req_write   = 1'b0;
      if_a.req_addr    = '0;
      if_a.req_wdata   = '0;
      if_a.clear_start = 1'b0;
      if_c.req_valid   = 1'b0;
      if_c.req_write   = 1'b0;
      if_c.req_addr    = '0;
      if_c.req_wdata   = '0;
      if_c.clear_start = 1'b0;
      test_reset();
      test_write_read();
      test_clear_with_read();
      test_hold_during_sweep();
      test_reset_mid_op();
      test_random();
      test_small_config();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
